// File: rtl/naval_board_responder_pkg.sv
// Shared definitions for the battleship board responder: response codes,
// FSM state encoding and default coordinate / ship-id widths.
package naval_pkg;

   localparam int DEF_COORD_W = 3;
   localparam int DEF_ID_W    = 2;

   typedef enum logic [1:0] {
      RESP_MISS   = 2'd0,
      RESP_HIT    = 2'd1,
      RESP_SUNK   = 2'd2,
      RESP_REPEAT = 2'd3
   } resp_code_e;

   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_ARMED = 3'd1,
      ST_CHECK = 3'd2,
      ST_RESP  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/naval_board_responder_if.sv
// Shot / response handshake bundle between the attacking player's move
// source (master) and the defending board responder (slave).
interface naval_board_responder_if
   import naval_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int ID_W    = DEF_ID_W
) ();

   logic               shot_valid;
   logic [COORD_W-1:0] shot_coord;
   logic               shot_ready;
   logic               resp_valid;
   logic               resp_ready;
   logic [1:0]         resp_code;
   logic [ID_W-1:0]    resp_id;

   modport master (
      output shot_valid, shot_coord, resp_ready,
      input  shot_ready, resp_valid, resp_code, resp_id
   );

   modport slave (
      input  shot_valid, shot_coord, resp_ready,
      output shot_ready, resp_valid, resp_code, resp_id
   );

endinterface

// File: rtl/naval_board_responder_tracker.sv
// Per-ship bookkeeping: length latched from the board at game start, hit
// counter per ship, "this hit sinks it" lookahead and the fleet-sunk flag.
// A ship of length 0 counts as already sunk so absent ships never block
// the end of the game.
module naval_ship_tracker
   import naval_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int CELLS   = 8,
   parameter int NSHIPS  = 3,
   parameter int ID_W    = DEF_ID_W
) (
   input  logic                        CLOCK_50,
   input  logic                        RESET_N,
   input  logic                        clear_i,
   input  logic                        latch_i,
   input  logic [CELLS-1:0][ID_W-1:0]  board_i,
   input  logic                        hitEn_i,
   input  logic [ID_W-1:0]             hitId_i,
   output logic                        hitSinks_o,
   output logic                        noShips_o,
   output logic                        allSunk_o
);

   localparam int CNT_W = ID_W + COORD_W + 1;

   logic [CNT_W-1:0] cellCount [NSHIPS];
   logic [CNT_W-1:0] len_q     [NSHIPS];
   logic [CNT_W-1:0] len_d     [NSHIPS];
   logic [CNT_W-1:0] hitCnt_q  [NSHIPS];
   logic [CNT_W-1:0] hitCnt_d  [NSHIPS];

   // Count how many board cells carry each ship id (ship s has id s+1).
   always_comb begin
      for (int s = 0; s < NSHIPS; s++) begin
         cellCount[s] = '0;
         for (int c = 0; c < CELLS; c++) begin
            if (board_i[c] == ID_W'(s + 1)) begin
               cellCount[s] = cellCount[s] + CNT_W'(1);
            end
         end
      end
   end

   // An empty fleet sends the game straight to its end at start.
   always_comb begin
      noShips_o = 1'b1;
      for (int s = 0; s < NSHIPS; s++) begin
         if (cellCount[s] != '0) begin
            noShips_o = 1'b0;
         end
      end
   end

   // Length latch on start, counter clear on new game, increment on a fresh hit.
   always_comb begin
      for (int s = 0; s < NSHIPS; s++) begin
         len_d[s]    = len_q[s];
         hitCnt_d[s] = hitCnt_q[s];
         if (clear_i) begin
            len_d[s]    = '0;
            hitCnt_d[s] = '0;
         end else if (latch_i) begin
            len_d[s]    = cellCount[s];
            hitCnt_d[s] = '0;
         end else if (hitEn_i && (hitId_i == ID_W'(s + 1))) begin
            hitCnt_d[s] = hitCnt_q[s] + CNT_W'(1);
         end
      end
   end

   // Lookahead used during the check cycle: would one more hit sink this ship.
   always_comb begin
      hitSinks_o = 1'b0;
      for (int s = 0; s < NSHIPS; s++) begin
         if ((hitId_i == ID_W'(s + 1)) && ((hitCnt_q[s] + CNT_W'(1)) == len_q[s])) begin
            hitSinks_o = 1'b1;
         end
      end
   end

   // Fleet is gone once every counter has caught up with its length.
   always_comb begin
      allSunk_o = 1'b1;
      for (int s = 0; s < NSHIPS; s++) begin
         if (hitCnt_q[s] != len_q[s]) begin
            allSunk_o = 1'b0;
         end
      end
   end

   // Length and hit counter registers.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int s = 0; s < NSHIPS; s++) begin
            len_q[s]    <= '0;
            hitCnt_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NSHIPS; s++) begin
            len_q[s]    <= len_d[s];
            hitCnt_q[s] <= hitCnt_d[s];
         end
      end
   end

endmodule

// File: rtl/naval_board_responder.sv
// Defending end of the battleship shot exchange. Holds one fleet on a
// CELLS-cell board, answers each accepted shot with MISS/HIT/SUNK/REPEAT
// and raises game_over once the whole fleet is sunk.
// Optional feature macro: NAVAL_SHOT_CNT_EN adds a saturating 8-bit
// shot_count output counting every accepted shot.
module naval_board_responder
   import naval_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int CELLS   = 8,
   parameter int NSHIPS  = 3,
   parameter int ID_W    = DEF_ID_W
) (
   input  logic               CLOCK_50,
   input  logic               RESET_N,
   input  logic               load_en,
   input  logic [COORD_W-1:0] load_coord,
   input  logic [ID_W-1:0]    load_id,
   input  logic               start,
   naval_board_responder_if.slave bus,
   output logic               game_over
`ifdef NAVAL_SHOT_CNT_EN
   ,
   output logic [7:0]         shot_count
`endif
);

   state_e                      state_q, state_d;
   logic [CELLS-1:0][ID_W-1:0]  board_q, board_d;
   logic [CELLS-1:0]            mask_q, mask_d;
   logic [COORD_W-1:0]          coord_q, coord_d;
   resp_code_e                  respCode_q, respCode_d;
   logic [ID_W-1:0]             respId_q, respId_d;

   logic       latch, clear, accept;
   logic       inRange, loadInRange, isRepeat, hitEn;
   logic       hitSinks, noShips, allSunk;
   logic [ID_W-1:0] cellId;
   resp_code_e shotCode;
   logic [ID_W-1:0] shotId;

   naval_ship_tracker #(
      .COORD_W (COORD_W),
      .CELLS   (CELLS),
      .NSHIPS  (NSHIPS),
      .ID_W    (ID_W)
   ) u_tracker (
      .CLOCK_50   (CLOCK_50),
      .RESET_N    (RESET_N),
      .clear_i    (clear),
      .latch_i    (latch),
      .board_i    (board_q),
      .hitEn_i    (hitEn),
      .hitId_i    (cellId),
      .hitSinks_o (hitSinks),
      .noShips_o  (noShips),
      .allSunk_o  (allSunk)
   );

   // Game flow; load_en wins over start in LOAD, stray start/load_en elsewhere are dropped.
   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      clear   = 1'b0;
      accept  = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (start && !load_en) begin
               latch   = 1'b1;
               state_d = noShips ? ST_DONE : ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (bus.shot_valid) begin
               accept  = 1'b1;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: state_d = ST_RESP;
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d = allSunk ? ST_DONE : ST_ARMED;
            end
         end
         ST_DONE: begin
            if (start) begin
               clear   = 1'b1;
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Classify the latched shot: off-board, already fired on, empty water or a ship.
   always_comb begin
      inRange     = 32'(coord_q) < CELLS;
      loadInRange = 32'(load_coord) < CELLS;
      cellId      = inRange ? board_q[coord_q] : '0;
      isRepeat    = inRange && mask_q[coord_q];
      hitEn       = (state_q == ST_CHECK) && inRange && !isRepeat && (cellId != '0);
      shotCode    = RESP_MISS;
      shotId      = '0;
      if (inRange) begin
         if (isRepeat) begin
            shotCode = RESP_REPEAT;
            shotId   = cellId;
         end else if (cellId != '0) begin
            shotCode = hitSinks ? RESP_SUNK : RESP_HIT;
            shotId   = cellId;
         end
      end
   end

   // Board, shot mask, latched coordinate and response register next values.
   always_comb begin
      board_d    = board_q;
      mask_d     = mask_q;
      coord_d    = coord_q;
      respCode_d = respCode_q;
      respId_d   = respId_q;
      if ((state_q == ST_LOAD) && load_en && loadInRange) begin
         board_d[load_coord] = load_id;
      end
      if (clear) begin
         board_d = '0;
         mask_d  = '0;
      end
      if (accept) begin
         coord_d = bus.shot_coord;
      end
      if (state_q == ST_CHECK) begin
         respCode_d = shotCode;
         respId_d   = shotId;
         if (inRange && !isRepeat) begin
            mask_d[coord_q] = 1'b1;
         end
      end
   end

   // State and datapath registers; reset aborts any game in progress.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_LOAD;
         board_q    <= '0;
         mask_q     <= '0;
         coord_q    <= '0;
         respCode_q <= RESP_MISS;
         respId_q   <= '0;
      end else begin
         state_q    <= state_d;
         board_q    <= board_d;
         mask_q     <= mask_d;
         coord_q    <= coord_d;
         respCode_q <= respCode_d;
         respId_q   <= respId_d;
      end
   end

   assign bus.shot_ready = (state_q == ST_ARMED);
   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.resp_code  = respCode_q;
   assign bus.resp_id    = respId_q;
   assign game_over      = (state_q == ST_DONE);

`ifdef NAVAL_SHOT_CNT_EN
   logic [7:0] shotCnt_q, shotCnt_d;

   // Accepted-shot counter, sticks at 255, restarts with a new game.
   always_comb begin
      shotCnt_d = shotCnt_q;
      if (clear) begin
         shotCnt_d = '0;
      end else if (accept && (shotCnt_q != 8'hFF)) begin
         shotCnt_d = shotCnt_q + 8'd1;
      end
   end

   // Shot counter register.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         shotCnt_q <= '0;
      end else begin
         shotCnt_q <= shotCnt_d;
      end
   end

   assign shot_count = shotCnt_q;
`endif

endmodule
